vga_sprite_engine: RTL and testbench

VGA_SPRITE_ENGINE -- requirements
Module: vga_sprite_engine

---
 rtl/vga_sprite_engine.sv | 200 ++++++++++++++++++++
 tb/tb_vga_sprite_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_engine.sv
// VGA raster generator with per-line sprite row prefetch in horizontal blanking
// and pending/active sprite registers swapped once per frame.
module vga_sprite_engine #(
  parameter int NUM_SPR = 2,
  parameter int SPR_W   = 64,
  parameter int SPR_H   = 48,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYN   = 96,
  parameter int H_BP    = 48,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYN   = 2,
  parameter int V_BP    = 33
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [3:0]                        wr_sel,
  input  logic [9:0]                        wr_x,
  input  logic [9:0]                        wr_y,
  input  logic [11:0]                       wr_color,
  input  logic [11:0]                       bg_color,
  output logic [$clog2(NUM_SPR*SPR_H)-1:0]  rom_addr,
  input  logic [SPR_W-1:0]                  rom_data,
  output logic                              hsync,
  output logic                              vsync,
  output logic [3:0]                        red,
  output logic [3:0]                        green,
  output logic [3:0]                        blue,
  output logic                              frame_start
);
  localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
  localparam int CW    = $clog2(H_TOT);
  localparam int RW    = $clog2(V_TOT);
  localparam int AW    = $clog2(NUM_SPR * SPR_H);
  localparam int BW    = $clog2(SPR_W);
  localparam int SW    = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOT - 1);
  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACT);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACT + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACT + H_FP + H_SYN);
  localparam logic [RW-1:0] V_LAST  = RW'(V_TOT - 1);
  localparam logic [RW-1:0] V_ACT_C = RW'(V_ACT);
  localparam logic [RW-1:0] VS_BEG  = RW'(V_ACT + V_FP);
  localparam logic [RW-1:0] VS_END  = RW'(V_ACT + V_FP + V_SYN);
  localparam logic [SW-1:0] K_LAST  = SW'(NUM_SPR - 1);

  typedef enum logic [1:0] {IDLE, ADDR, LATCH} fetch_t;

  logic          pix_en;
  logic [CW-1:0] hc;
  logic [RW-1:0] vc;

  logic [9:0]       pend_x [NUM_SPR];
  logic [9:0]       pend_y [NUM_SPR];
  logic [11:0]      pend_c [NUM_SPR];
  logic [9:0]       act_x  [NUM_SPR];
  logic [9:0]       act_y  [NUM_SPR];
  logic [11:0]      act_c  [NUM_SPR];
  logic [SPR_W-1:0] row_buf[NUM_SPR];

  fetch_t        state;
  logic [SW-1:0] fk;
  logic [RW-1:0] nv;
  logic          in_rng;

  // Pixel colour for the current (hc,vc); 11-bit compares keep right-edge clipping wrap-free.
  logic [10:0] hc_x;
  logic [10:0] dx;
  logic [11:0] pix_color;
  logic        in_act;

  assign hc_x   = 11'(hc);
  assign in_act = (hc < H_ACT_C) && (vc < V_ACT_C);

  // NOTE: always_comb uses blocking assignments and sets every output first, so no latch forms.
  always_comb begin
    pix_color = bg_color;
    dx        = '0;
    for (int k = NUM_SPR - 1; k >= 0; k--) begin
      dx = hc_x - 11'(act_x[k]);
      if (hc_x >= 11'(act_x[k]) && hc_x < 11'(act_x[k]) + 11'(SPR_W) &&
          row_buf[k][BW'(SPR_W - 1) - dx[BW-1:0]])
        pix_color = act_c[k];
    end
  end

  // Address for the sprite the fetch FSM is about to request, on the line being prefetched.
  logic [RW-1:0] nv_next;
  logic [SW-1:0] ak;
  logic [RW-1:0] al;
  logic [10:0]   al_x;
  logic [10:0]   ay_x;
  logic          ak_hit;
  logic [AW-1:0] ak_addr;

  assign nv_next = (vc == V_LAST) ? '0 : vc + RW'(1);

  always_comb begin
    ak      = (state == IDLE) ? '0 : fk + SW'(1);
    al      = (state == IDLE) ? nv_next : nv;
    al_x    = 11'(al);
    ay_x    = 11'(act_y[ak]);
    ak_hit  = (al_x >= ay_x) && (al_x < ay_x + 11'(SPR_H));
    ak_addr = AW'(int'(ak) * SPR_H + int'(al_x - ay_x));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_en      <= 1'b0;
      hc          <= '0;
      vc          <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
      // NOTE: sprite register arrays are small flop banks, so they take the async reset like any flop.
      for (int k = 0; k < NUM_SPR; k++) begin
        pend_x[k] <= '0;
        pend_y[k] <= '0;
        pend_c[k] <= '0;
        act_x[k]  <= '0;
        act_y[k]  <= '0;
        act_c[k]  <= '0;
      end
    end else begin
      pix_en      <= ~pix_en;
      frame_start <= 1'b0;
      if (pix_en) begin
        if (hc == H_LAST) begin
          hc <= '0;
          vc <= (vc == V_LAST) ? '0 : vc + RW'(1);
        end else begin
          hc <= hc + CW'(1);
        end
        hsync <= !((hc >= HS_BEG) && (hc < HS_END));
        vsync <= !((vc >= VS_BEG) && (vc < VS_END));
        {red, green, blue} <= in_act ? pix_color : 12'h000;
        if (hc == '0 && vc == V_ACT_C) begin
          act_x       <= pend_x;
          act_y       <= pend_y;
          act_c       <= pend_c;
          frame_start <= 1'b1;
        end
      end
      // A write coinciding with the swap lands in pending only; the swap above sees the old value.
      for (int k = 0; k < NUM_SPR; k++) begin
        if (wr_en && wr_sel == 4'(k)) begin
          pend_x[k] <= wr_x;
          pend_y[k] <= wr_y;
          pend_c[k] <= wr_color;
        end
      end
    end
  end

  // Fetch FSM: ADDR presents the row address, LATCH captures the ROM word one clk later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fk       <= '0;
      nv       <= '0;
      in_rng   <= 1'b0;
      rom_addr <= '0;
      for (int k = 0; k < NUM_SPR; k++) row_buf[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pix_en && hc == H_ACT_C) begin
            nv     <= nv_next;
            fk     <= '0;
            in_rng <= ak_hit;
            if (ak_hit) rom_addr <= ak_addr;
            state  <= ADDR;
          end
        end
        ADDR: state <= LATCH;
        LATCH: begin
          row_buf[fk] <= in_rng ? rom_data : '0;
          if (fk == K_LAST) begin
            state <= IDLE;
          end else begin
            fk     <= fk + SW'(1);
            in_rng <= ak_hit;
            if (ak_hit) rom_addr <= ak_addr;
            state  <= ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Scoreboard bench for vga_sprite_engine on a scaled-down raster; expected pixels come
// from a direct sprite/ROM model, expected sync and frame_start from raster counters.
module tb_vga_sprite_engine;
  localparam int NUM_SPR = 2;
  localparam int SPR_W   = 16;
  localparam int SPR_H   = 8;
  localparam int H_ACT = 64, H_FP = 4, H_SYN = 8, H_BP = 4;
  localparam int V_ACT = 40, V_FP = 2, V_SYN = 2, V_BP = 2;
  localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
  localparam int AW    = $clog2(NUM_SPR * SPR_H);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic [3:0]       wr_sel = '0;
  logic [9:0]       wr_x = '0;
  logic [9:0]       wr_y = '0;
  logic [11:0]      wr_color = '0;
  logic [11:0]      bg_color = 12'hFFF;
  logic [AW-1:0]    rom_addr;
  logic [SPR_W-1:0] rom_data;
  logic             hsync, vsync, frame_start;
  logic [3:0]       red, green, blue;

  logic [SPR_W-1:0] rom [NUM_SPR*SPR_H];

  vga_sprite_engine #(
    .NUM_SPR(NUM_SPR), .SPR_W(SPR_W), .SPR_H(SPR_H),
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYN(H_SYN), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYN(V_SYN), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_x(wr_x), .wr_y(wr_y),
    .wr_color(wr_color), .bg_color(bg_color), .rom_addr(rom_addr), .rom_data(rom_data),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        chk;
  } exp_t;

  exp_t sb[$];
  exp_t last;

  int total = 0;
  int bad   = 0;

  int          m_hc, m_vc;
  bit          m_pix;
  bit          chk_pix;
  int          pend_x[NUM_SPR], pend_y[NUM_SPR], act_x[NUM_SPR], act_y[NUM_SPR];
  logic [11:0] pend_c[NUM_SPR], act_c[NUM_SPR];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_color(input int x, input int y);
    logic [11:0]      c;
    logic [SPR_W-1:0] row;
    c = bg_color;
    for (int k = NUM_SPR - 1; k >= 0; k--) begin
      if (x >= act_x[k] && x < act_x[k] + SPR_W && y >= act_y[k] && y < act_y[k] + SPR_H) begin
        row = rom[k * SPR_H + y - act_y[k]];
        if (row[SPR_W - 1 - (x - act_x[k])]) c = act_c[k];
      end
    end
    return c;
  endfunction

  task automatic model_reset();
    m_hc = 0; m_vc = 0; m_pix = 1'b0; chk_pix = 1'b0;
    for (int k = 0; k < NUM_SPR; k++) begin
      pend_x[k] = 0; pend_y[k] = 0; pend_c[k] = '0;
      act_x[k]  = 0; act_y[k]  = 0; act_c[k]  = '0;
    end
    last = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, fs: 1'b0, chk: 1'b0};
  endtask

  // One clk: model the edge, push the expectation, then pop and compare after the edge.
  task automatic step();
    exp_t e, got;
    @(posedge clk);
    e     = last;
    e.fs  = 1'b0;
    e.chk = chk_pix;
    if (m_pix) begin
      e.rgb = (m_hc < H_ACT && m_vc < V_ACT) ? model_color(m_hc, m_vc) : 12'h000;
      e.hs  = (m_hc >= H_ACT + H_FP && m_hc < H_ACT + H_FP + H_SYN) ? 1'b0 : 1'b1;
      e.vs  = (m_vc >= V_ACT + V_FP && m_vc < V_ACT + V_FP + V_SYN) ? 1'b0 : 1'b1;
      if (m_hc == 0 && m_vc == V_ACT) begin
        act_x = pend_x; act_y = pend_y; act_c = pend_c;
        e.fs    = 1'b1;
        chk_pix = 1'b1;
      end
      if (m_hc == H_TOT - 1) begin
        m_hc = 0;
        m_vc = (m_vc == V_TOT - 1) ? 0 : m_vc + 1;
      end else begin
        m_hc++;
      end
    end
    if (wr_en && int'(wr_sel) < NUM_SPR) begin
      pend_x[int'(wr_sel)] = int'(wr_x);
      pend_y[int'(wr_sel)] = int'(wr_y);
      pend_c[int'(wr_sel)] = wr_color;
    end
    m_pix = !m_pix;
    last  = e;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    check("hsync", 32'(hsync), 32'(got.hs));
    check("vsync", 32'(vsync), 32'(got.vs));
    check("frame_start", 32'(frame_start), 32'(got.fs));
    if (got.chk) check("rgb", 32'({red, green, blue}), 32'(got.rgb));
  endtask

  task automatic wr(input int sel, input int x, input int y, input int c);
    wr_en = 1'b1; wr_sel = 4'(sel); wr_x = 10'(x); wr_y = 10'(y); wr_color = 12'(c);
    step();
    wr_en = 1'b0;
  endtask

  // Step until the next clk edge is the pixel edge at which the counters hold (hc,vc).
  task automatic run_to(input int hc, input int vc);
    int n;
    n = 0;
    while (!(m_pix && m_hc == hc && m_vc == vc) && n < 2 * H_TOT * V_TOT + 4) begin
      step();
      n++;
    end
    if (!(m_pix && m_hc == hc && m_vc == vc)) check("run_to_bound", 32'(n), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsync"}, 32'(hsync), 32'(1));
    check({tag, "_vsync"}, 32'(vsync), 32'(1));
    check({tag, "_rgb"}, 32'({red, green, blue}), 32'(0));
    check({tag, "_frame_start"}, 32'(frame_start), 32'(0));
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    for (int r = 0; r < SPR_H; r++) begin
      rom[r]         = 16'hFFFF;
      rom[SPR_H + r] = (r % 2 == 1) ? 16'h0FF0 : 16'hFFFF;
    end
    rom[1] = 16'hFF0F;
    rom[4] = 16'h7FFE;

    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    model_reset();

    // Frame 0: load pending; sel 2 is out of range and must not disturb sprite 0.
    wr(0, 10, 5, 12'hF00);
    wr(1, 20, 0, 12'h0F0);
    wr(2, 0, 0, 12'h00F);
    run_to(0, V_ACT);
    step();

    // Frame 1 shows overlap; move sprite 0 to the clipping corner mid-frame.
    run_to(0, 20);
    wr(0, 56, 34, 12'hF00);
    run_to(0, V_ACT);
    wr(1, 40, 20, 12'h00F);
    bg_color = 12'h123;

    // Frame 2: sprite 0 clipped at right/bottom, sprite 1 still at top edge.
    run_to(0, V_ACT);
    step();
    // Frame 3: the write made on the swap edge now shows.
    run_to(0, V_ACT);
    step();

    // Reset in the middle of a row fetch, then confirm timing restarts from (0,0).
    run_to(H_ACT, 5);
    step();
    step();
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_fetch_rst");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    model_reset();
    run_to(0, 3);
    run_to(H_ACT + H_FP + H_SYN + 2, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
